pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field decode→execute register.
- Carries an opaque DATA_W-bit payload. Callers pack alu_op, operands, write address, delay-slot flags, instruction, PC and excepttype into it.
- MODE 0 keeps the legacy stall-vector semantics: load, hold, or inject a bubble.
- MODE 1 adds a valid/ready handshake with a 2-entry skid buffer, plus a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 128, payload width in bits (≥1).
NOP_VALUE, {DATA_W{1'b0}}, payload driven whenever the stage holds no valid entry (bubble encoding).
MODE, 0, 0 = legacy stall mode; 1 = valid/ready handshake with skid buffer.
CNT_W, 16, bubble counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard all held entries (exception/branch flush).
stall_up  in  1  MODE 0: this stage stalled (stall[n]); ignored in MODE 1.
stall_dn  in  1  MODE 0: downstream stage stalled (stall[n+1]); ignored in MODE 1.
in_valid  in  1  upstream payload valid.
in_data  in  DATA_W  upstream payload.
in_ready  out  1  stage can accept in_data this cycle.
out_valid  out  1  out_data holds a valid entry.
out_data  out  DATA_W  payload to next stage; NOP_VALUE when !out_valid.
out_ready  in  1  MODE 1: downstream consumes; ignored in MODE 0.
cnt_clr  in  1  clear bubble counter.
bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

Behaviour:
- State: main_valid/main_data, skid_valid/skid_data (skid exists only in MODE 1), bubble counter.
- out_valid = main_valid. out_data = main_valid ? main_data : NOP_VALUE (combinational mux off the registers).
- Reset (rst=1 at a clock edge): main_valid=0, skid_valid=0, bubble_cnt=0. Hence out_valid=0, out_data=NOP_VALUE, in_ready=1. rst beats every other input.
- Flush (flush=1, rst=0): main_valid=0 and skid_valid=0 next cycle. Any same-cycle input is dropped. In MODE 1, in_ready=1 the cycle after. In MODE 0 a flush also overrides stalls.
- MODE 0, evaluated in priority order rst > flush > bubble > load > hold:
  - bubble (stall_up=1, stall_dn=0): main_valid<=0.
  - load (stall_up=0): main_valid<=in_valid, main_data<=in_data.
  - hold (stall_up=1, stall_dn=1): registers unchanged.
  - in_ready = !stall_up (combinational).
  - Latency 1 cycle.
- MODE 1:
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - accept = in_valid & in_ready; drain = main_valid & out_ready.
  - main empty, accept → main<=in; valid at out next cycle (latency 1).
  - main full, drain, accept, skid empty → main<=in (back-to-back, full throughput).
  - main full, !drain, accept → skid<=in; in_ready=0 next cycle.
  - main full, drain, skid full → main<=skid, skid_valid<=0; no accept this cycle because in_ready=0.
  - main full, !drain → main held stable. Payload must not change while out_valid & !out_ready.
  - Ordering is strict FIFO; there is no loss or duplication.
- Bubble counter:
  - Each non-reset cycle with out_valid=0, bubble_cnt increments, saturating at 2^CNT_W-1.
  - cnt_clr has priority over the increment and sets the counter to 0.
  - Flush does not clear the counter.
- Reset mid-operation discards both entries with no partial output. The first post-reset out_valid occurs ≥1 cycle after the first accept.

Test Plan:
- Reset check, MODE 1, DATA_W=32: hold rst for 2 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid=0, out_data=0x0, in_ready=1, bubble_cnt=0.
- MODE 0 stall sequence: load 0x11, then stall_up=1/stall_dn=1 for 2 cycles, then stall_up=1/stall_dn=0 for 1 cycle → out_data 0x11, 0x11, 0x11, then NOP_VALUE with out_valid=0; bubble_cnt increments by 1.
- MODE 1 streaming: in_valid=1 with values 1..8 on consecutive cycles, out_ready=1 → out_data 1..8 one cycle later, one per cycle, in_ready never 0.
- MODE 1 skid: stream 1,2,3 while out_ready=0 from cycle 1 → main=1, skid=2, in_ready=0, 3 held off. Raise out_ready → outputs 1,2,3 in order, no loss or duplication.
- Flush with full skid: main=0xA, skid=0xB, in_valid=1 with 0xC, flush=1 → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1, 0xC never appears.
- Counter, CNT_W=3: 10 idle cycles → bubble_cnt saturates at 7; cnt_clr=1 → 0 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: the upstream payload going in, the payload
// going out, and the ready signals in each direction.
// slave  : the view of the stage register itself.
// master : the view of the logic that surrounds the stage (upstream producer plus downstream consumer).
interface pipe_stage_reg_if #(
   parameter int DATA_W = 128
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Purpose: parametrised pipeline stage register carrying an opaque payload.
//          It also keeps a saturating count of bubble cycles.
// Latency: 1 cycle from input accept to out_valid in both modes.
// Backpressure: MODE 0 holds or bubbles under the legacy stall vector.
//               MODE 1 uses valid/ready with a 2-entry skid buffer.
//               In MODE 1, in_ready is registered (!skid_valid).
// Ports:
//   clk, rst  - clock; synchronous active-high reset.
//   flush     - drops every held entry; any same-cycle input is also dropped.
//   stall_up  - MODE 0 only: this stage is stalled (stall[n]).
//   stall_dn  - MODE 0 only: the downstream stage is stalled (stall[n+1]).
//   cnt_clr   - clears bubble_cnt.
//   bubble_cnt - saturating count of cycles with out_valid=0.
//   bus       - in_valid/in_data/in_ready in, out_valid/out_data/out_ready out.
module pipe_stage_reg #(
   parameter int                DATA_W    = 128,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int                MODE      = 0,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall_up,
   input  logic              stall_dn,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  bubble_cnt,
   pipe_stage_reg_if.slave   bus
);

   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   // The skid entry is only ever written in MODE 1. In MODE 0 it stays at its reset value.
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;

   logic accept;
   logic drain;

   assign accept = bus.in_valid & bus.in_ready;
   assign drain  = main_valid & bus.out_ready;

   // MODE 1 ready depends only on the skid register.
   // This keeps any combinational path from out_ready to in_ready out of the design.
   assign bus.in_ready  = (MODE == 0) ? !stall_up : !skid_valid;
   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_valid ? main_data : NOP_VALUE;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (MODE == 0) begin
         if (!stall_up) begin
            main_valid <= bus.in_valid;
            main_data  <= bus.in_data;
         end else if (!stall_dn) begin
            // This stage is stalled but the next one is not, so insert a bubble.
            main_valid <= 1'b0;
         end
      end else begin
         if (!main_valid || drain) begin
            if (skid_valid) begin
               // The oldest entry sits in skid. No accept is possible here because in_ready=0.
               main_valid <= 1'b1;
               main_data  <= skid_data;
               skid_valid <= 1'b0;
            end else begin
               main_valid <= accept;
               if (accept) begin
                  main_data <= bus.in_data;
               end
            end
         end else if (accept) begin
            // Main is full and stalled, so park the new entry in skid.
            skid_valid <= 1'b1;
            skid_data  <= bus.in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         bubble_cnt <= '0;
      end else if (!main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg.
// u0: MODE 0 with a non-zero NOP encoding.
// u1: MODE 1 with default parameters at 32 bits.
// u2: MODE 1 with a 3-bit counter.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   localparam logic [31:0] NOP0 = 32'h0000_0013;

   pipe_stage_reg_if #(.DATA_W(32)) if0 ();
   pipe_stage_reg_if #(.DATA_W(32)) if1 ();
   pipe_stage_reg_if #(.DATA_W(32)) if2 ();

   logic        flush0, su0, sd0, clr0;
   logic        flush1, clr1;
   logic        flush2, clr2;
   logic [15:0] cnt0, cnt1;
   logic [2:0]  cnt2;

   pipe_stage_reg #(.DATA_W(32), .NOP_VALUE(NOP0), .MODE(0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .flush(flush0), .stall_up(su0), .stall_dn(sd0),
      .cnt_clr(clr0), .bubble_cnt(cnt0), .bus(if0));

   pipe_stage_reg #(.DATA_W(32), .MODE(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .flush(flush1), .stall_up(1'b0), .stall_dn(1'b0),
      .cnt_clr(clr1), .bubble_cnt(cnt1), .bus(if1));

   pipe_stage_reg #(.DATA_W(32), .MODE(1), .CNT_W(3)) u2 (
      .clk(clk), .rst(rst), .flush(flush2), .stall_up(1'b0), .stall_dn(1'b0),
      .cnt_clr(clr2), .bubble_cnt(cnt2), .bus(if2));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
      end
   endtask

   // Inputs change #1 after the edge, and outputs are sampled at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        fl, su, sd, iv;
      logic [31:0] id;
      logic        clr;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_ir;
      logic [15:0] e_cnt;
   } m0_vec_t;

   m0_vec_t tbl[9];

   initial begin
      // MODE 0 vectors. Inputs are applied for one edge, then outputs are compared.
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 1'b1, 16'd0}; // load, clear counter
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 16'd0}; // hold
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0, 16'd0}; // hold
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0, NOP0,   1'b0, 16'd0}; // bubble
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, NOP0,   1'b0, 16'd1}; // hold empty
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h55, 1'b0, 1'b0, NOP0,   1'b1, 16'd2}; // load invalid
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 1'b0, 1'b1, 32'h66, 1'b1, 16'd3}; // load
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0, NOP0,   1'b0, 16'd3}; // flush beats stall
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h88, 1'b0, 1'b1, 32'h88, 1'b1, 16'd4}; // load

      rst = 1'b1;
      flush0 = 1'b0; su0 = 1'b0; sd0 = 1'b0; clr0 = 1'b0;
      flush1 = 1'b0; clr1 = 1'b0; flush2 = 1'b0; clr2 = 1'b0;
      if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
      if1.in_valid = 1'b1; if1.in_data = 32'hDEAD_BEEF; if1.out_ready = 1'b0;
      if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;

      // Reset wins over an active input.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ov", {31'b0, if1.out_valid}, 32'd0);
         chk("rst_od", if1.out_data, 32'h0);
         chk("rst_ir", {31'b0, if1.in_ready}, 32'd1);
         chk("rst_cnt", {16'b0, cnt1}, 32'd0);
      end
      rst = 1'b0;
      if1.in_valid = 1'b0;

      // MODE 0 table.
      for (int i = 0; i < 9; i++) begin
         flush0 = tbl[i].fl; su0 = tbl[i].su; sd0 = tbl[i].sd;
         if0.in_valid = tbl[i].iv; if0.in_data = tbl[i].id; clr0 = tbl[i].clr;
         tick();
         chk($sformatf("m0_ov[%0d]", i), {31'b0, if0.out_valid}, {31'b0, tbl[i].e_ov});
         chk($sformatf("m0_od[%0d]", i), if0.out_data, tbl[i].e_od);
         chk($sformatf("m0_ir[%0d]", i), {31'b0, if0.in_ready}, {31'b0, tbl[i].e_ir});
         chk($sformatf("m0_cnt[%0d]", i), {16'b0, cnt0}, {16'b0, tbl[i].e_cnt});
      end

      // MODE 1: stream eight values with downstream always ready.
      if1.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if1.in_valid = 1'b1; if1.in_data = k;
         tick();
         chk($sformatf("str_ir[%0d]", k), {31'b0, if1.in_ready}, 32'd1);
         chk($sformatf("str_ov[%0d]", k), {31'b0, if1.out_valid}, 32'd1);
         chk($sformatf("str_od[%0d]", k), if1.out_data, k);
      end
      if1.in_valid = 1'b0;
      tick();
      chk("str_end_ov", {31'b0, if1.out_valid}, 32'd0);

      // MODE 1 skid: downstream stalls while 1, 2 and 3 are offered.
      if1.out_ready = 1'b0;
      if1.in_valid = 1'b1; if1.in_data = 32'd1; tick();
      chk("skid_od1", if1.out_data, 32'd1);
      chk("skid_ir1", {31'b0, if1.in_ready}, 32'd1);
      if1.in_data = 32'd2; tick();
      chk("skid_od2", if1.out_data, 32'd1);
      chk("skid_ir2", {31'b0, if1.in_ready}, 32'd0);
      if1.in_data = 32'd3; tick();
      chk("skid_hold_od", if1.out_data, 32'd1);
      chk("skid_hold_ir", {31'b0, if1.in_ready}, 32'd0);
      if1.out_ready = 1'b1; tick();
      chk("skid_rel_od2", if1.out_data, 32'd2);
      chk("skid_rel_ir", {31'b0, if1.in_ready}, 32'd1);
      tick();
      chk("skid_rel_od3", if1.out_data, 32'd3);
      chk("skid_rel_ov3", {31'b0, if1.out_valid}, 32'd1);
      if1.in_valid = 1'b0; tick();
      chk("skid_drained", {31'b0, if1.out_valid}, 32'd0);

      // Flush with both entries full and a new input on the same cycle.
      if1.out_ready = 1'b0;
      if1.in_valid = 1'b1; if1.in_data = 32'hA; tick();
      if1.in_data = 32'hB; tick();
      chk("fl_pre_ir", {31'b0, if1.in_ready}, 32'd0);
      if1.in_data = 32'hC; flush1 = 1'b1; tick();
      chk("fl_ov", {31'b0, if1.out_valid}, 32'd0);
      chk("fl_od", if1.out_data, 32'h0);
      chk("fl_ir", {31'b0, if1.in_ready}, 32'd1);
      flush1 = 1'b0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("fl_after_ov[%0d]", i), {31'b0, if1.out_valid}, 32'd0);
      end

      // Reset mid-operation discards both held entries.
      if1.out_ready = 1'b0;
      if1.in_valid = 1'b1; if1.in_data = 32'd5; tick();
      if1.in_data = 32'd6; tick();
      rst = 1'b1; if1.in_data = 32'd7; tick();
      chk("rstmid_ov", {31'b0, if1.out_valid}, 32'd0);
      chk("rstmid_ir", {31'b0, if1.in_ready}, 32'd1);
      chk("cnt_rst", {29'b0, cnt2}, 32'd0);
      rst = 1'b0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;

      // Counter saturation on u2 (3 bits). u2 is idle from here on.
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1) chk("rstmid_after_ov", {31'b0, if1.out_valid}, 32'd0);
         chk($sformatf("cnt_sat[%0d]", i), {29'b0, cnt2}, (i > 7) ? 32'd7 : i);
      end
      clr2 = 1'b1; tick();
      chk("cnt_clr", {29'b0, cnt2}, 32'd0);
      clr2 = 1'b0; flush2 = 1'b1; tick();
      chk("cnt_flush_keeps", {29'b0, cnt2}, 32'd1);
      flush2 = 1'b0; tick();
      chk("cnt_resume", {29'b0, cnt2}, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
